// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 mouse receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        B0 = 2'd0,
        B1 = 2'd1,
        B2 = 2'd2
    } pkt_state_t;

    localparam int PS2_FRAME_BITS = 11;

    // Bit positions inside the first (status) byte of a stream packet
    localparam int BTN_L = 0;
    localparam int BTN_R = 1;
    localparam int BTN_M = 2;
    localparam int SYNC  = 3;
    localparam int XS    = 4;
    localparam int YS    = 5;
    localparam int XO    = 6;
    localparam int YO    = 7;

    function automatic logic [8:0] sat_delta(input logic sign, input logic ovf, input logic [7:0] mag);
        logic [8:0] res;
        if (ovf) begin
            res = sign ? 9'h100 : 9'h0FF;
        end else begin
            res = {sign, mag};
        end
        return res;
    endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pad synchronisers, falling-edge detect, 11-bit frame FSM
// with odd-parity/stop checking and a mid-frame inactivity timeout.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_err
);

    localparam int DATA_BITS = PS2_FRAME_BITS - 3;
    localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]    r_clk_sync;
    logic [1:0]    r_dat_sync;
    rx_state_t     r_state;
    rx_state_t     w_state_nxt;
    logic [7:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_parity;
    logic [TW-1:0] r_to_cnt;
    logic          w_fall;
    logic          w_dat;
    logic          w_timeout;
    logic          w_odd_ok;
    logic          w_valid;
    logic          w_err;

    // Two-flop synchronisers; r_clk_sync[2] keeps the previous synced clock level
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_clk_sync <= 3'b111;
            r_dat_sync <= 2'b11;
        end else begin
            r_clk_sync <= {r_clk_sync[1:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[0], i_ps2_dat};
        end
    end

    assign w_fall    = r_clk_sync[2] & ~r_clk_sync[1];
    assign w_dat     = r_dat_sync[1];
    assign w_timeout = (r_state != IDLE) && (r_to_cnt == TW'(TIMEOUT_CYCLES));
    assign w_odd_ok  = ^{r_shift, r_parity};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else if (w_fall) begin
            case (r_state)
                IDLE:    w_state_nxt = w_dat ? IDLE : DATA;
                DATA:    w_state_nxt = (r_bit_cnt == 3'(DATA_BITS - 1)) ? PARITY : DATA;
                PARITY:  w_state_nxt = STOP;
                STOP:    w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end else begin
            w_state_nxt = r_state;
        end
    end

    // Timeout takes priority so a frame can never both complete and abort
    always_comb begin
        w_valid = 1'b0;
        w_err   = 1'b0;
        if (w_timeout) begin
            w_err = 1'b1;
        end else if (w_fall) begin
            case (r_state)
                IDLE: w_err = w_dat;
                STOP: begin
                    if (w_odd_ok && w_dat) begin
                        w_valid = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: begin
                    w_valid = 1'b0;
                    w_err   = 1'b0;
                end
            endcase
        end else begin
            w_valid = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_shift      <= 8'h00;
            r_bit_cnt    <= 3'd0;
            r_parity     <= 1'b0;
            r_to_cnt     <= '0;
            o_byte       <= 8'h00;
            o_byte_valid <= 1'b0;
            o_err        <= 1'b0;
        end else begin
            o_byte_valid <= w_valid;
            o_err        <= w_err;
            if (w_valid) begin
                o_byte <= r_shift;
            end
            if (w_fall || (r_state == IDLE)) begin
                r_to_cnt <= '0;
            end else if (r_to_cnt != TW'(TIMEOUT_CYCLES)) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end
            if (r_state == IDLE) begin
                r_bit_cnt <= 3'd0;
            end else if (w_fall && (r_state == DATA)) begin
                r_shift   <= {w_dat, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
            if (w_fall && (r_state == PARITY)) begin
                r_parity <= w_dat;
            end
        end
    end

endmodule

// File: rtl/mouse_packet_decoder.sv
// PS/2 mouse stream-packet decoder: assembles 3 received bytes into dx/dy/buttons.
// Define MOUSE_OVF_SAT_EN to saturate dx/dy when the packet overflow bits are set.
module mouse_packet_decoder
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic       new_data,
    output logic [8:0] dx,
    output logic [8:0] dy,
    output logic       m1,
    output logic       m2,
    output logic       m3,
    output logic       frame_err
);

    logic [7:0] w_byte;
    logic       w_byte_valid;
    logic       w_rx_err;
    pkt_state_t r_pkt_state;
    pkt_state_t w_pkt_nxt;
    logic       w_load_hdr;
    logic       w_load_b1;
    logic       w_pkt_done;
    logic [2:0] r_btn;
    logic       r_xs;
    logic       r_ys;
    logic [7:0] r_b1;
    logic       w_x_ovf;
    logic       w_y_ovf;

    ps2_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .i_clk       (Clk),
        .i_rst       (Reset),
        .i_ps2_clk   (PS2_CLK),
        .i_ps2_dat   (PS2_DAT),
        .o_byte      (w_byte),
        .o_byte_valid(w_byte_valid),
        .o_err       (w_rx_err)
    );

`ifdef MOUSE_OVF_SAT_EN
    logic r_xo;
    logic r_yo;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_xo <= 1'b0;
            r_yo <= 1'b0;
        end else if (w_load_hdr) begin
            r_xo <= w_byte[XO];
            r_yo <= w_byte[YO];
        end
    end

    assign w_x_ovf = r_xo;
    assign w_y_ovf = r_yo;
`else
    assign w_x_ovf = 1'b0;
    assign w_y_ovf = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_pkt_state <= B0;
        end else begin
            r_pkt_state <= w_pkt_nxt;
        end
    end

    // A header without the always-one sync bit is dropped so the stream can realign
    always_comb begin
        w_pkt_nxt = r_pkt_state;
        if (w_rx_err) begin
            w_pkt_nxt = B0;
        end else if (w_byte_valid) begin
            case (r_pkt_state)
                B0:      w_pkt_nxt = w_byte[SYNC] ? B1 : B0;
                B1:      w_pkt_nxt = B2;
                B2:      w_pkt_nxt = B0;
                default: w_pkt_nxt = B0;
            endcase
        end else begin
            w_pkt_nxt = r_pkt_state;
        end
    end

    always_comb begin
        w_load_hdr = 1'b0;
        w_load_b1  = 1'b0;
        w_pkt_done = 1'b0;
        if (w_byte_valid) begin
            case (r_pkt_state)
                B0:      w_load_hdr = w_byte[SYNC];
                B1:      w_load_b1  = 1'b1;
                B2:      w_pkt_done = 1'b1;
                default: w_pkt_done = 1'b0;
            endcase
        end else begin
            w_pkt_done = 1'b0;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_btn     <= 3'b000;
            r_xs      <= 1'b0;
            r_ys      <= 1'b0;
            r_b1      <= 8'h00;
            dx        <= 9'h000;
            dy        <= 9'h000;
            m1        <= 1'b0;
            m2        <= 1'b0;
            m3        <= 1'b0;
            new_data  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            new_data  <= w_pkt_done;
            frame_err <= w_rx_err;
            if (w_load_hdr) begin
                r_btn <= {w_byte[BTN_M], w_byte[BTN_R], w_byte[BTN_L]};
                r_xs  <= w_byte[XS];
                r_ys  <= w_byte[YS];
            end
            if (w_load_b1) begin
                r_b1 <= w_byte;
            end
            if (w_pkt_done) begin
                dx <= sat_delta(r_xs, w_x_ovf, r_b1);
                dy <= sat_delta(r_ys, w_y_ovf, w_byte);
                m1 <= r_btn[0];
                m2 <= r_btn[1];
                m3 <= r_btn[2];
            end
        end
    end

endmodule

// File: tb/tb_mouse_packet_decoder.sv
// Directed bench for mouse_packet_decoder; honours MOUSE_OVF_SAT_EN for overflow expectations.
module tb_mouse_packet_decoder;

    localparam int TO = 400;
    localparam int HP = 20;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       PS2_CLK;
    logic       PS2_DAT;
    logic       new_data;
    logic       frame_err;
    logic       m1;
    logic       m2;
    logic       m3;
    logic [8:0] dx;
    logic [8:0] dy;

    int checks   = 0;
    int passes   = 0;
    int nd_cnt   = 0;
    int fe_cnt   = 0;
    int both_cnt = 0;
    int nd0;
    int fe0;

    always #5 Clk = ~Clk;

    mouse_packet_decoder #(
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .PS2_CLK  (PS2_CLK),
        .PS2_DAT  (PS2_DAT),
        .new_data (new_data),
        .dx       (dx),
        .dy       (dy),
        .m1       (m1),
        .m2       (m2),
        .m3       (m3),
        .frame_err(frame_err)
    );

    always @(negedge Clk) begin
        if (new_data) nd_cnt++;
        if (frame_err) fe_cnt++;
        if (new_data && frame_err) both_cnt++;
    end

    task automatic ps2_bit(input logic b);
        @(negedge Clk);
        PS2_DAT = b;
        repeat (HP) @(negedge Clk);
        PS2_CLK = 1'b0;
        repeat (HP) @(negedge Clk);
        PS2_CLK = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic bad_par);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(1'b1);
        PS2_DAT = 1'b1;
        repeat (2 * HP) @(negedge Clk);
    endtask

    task automatic send_pkt(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_byte(b0, 1'b0);
        send_byte(b1, 1'b0);
        send_byte(b2, 1'b0);
    endtask

    task automatic mark();
        nd0 = nd_cnt;
        fe0 = fe_cnt;
    endtask

    task automatic test_reset();
        Reset   = 1'b0;
        PS2_CLK = 1'b1;
        PS2_DAT = 1'b1;
        #1 Reset = 1'b1;
        repeat (4) @(negedge Clk);
        checks++; if (new_data !== 1'b0) $display("FAIL rst_new_data got %b exp 0", new_data); else passes++;
        checks++; if (frame_err !== 1'b0) $display("FAIL rst_frame_err got %b exp 0", frame_err); else passes++;
        checks++; if (dx !== 9'h000) $display("FAIL rst_dx got %h exp 000", dx); else passes++;
        checks++; if (dy !== 9'h000) $display("FAIL rst_dy got %h exp 000", dy); else passes++;
        checks++; if ({m1, m2, m3} !== 3'b000) $display("FAIL rst_buttons got %b exp 000", {m1, m2, m3}); else passes++;
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic test_basic();
        mark();
        send_pkt(8'h09, 8'h05, 8'hFB);
        checks++; if (nd_cnt - nd0 !== 1) $display("FAIL basic_new_data got %0d exp 1", nd_cnt - nd0); else passes++;
        checks++; if (fe_cnt - fe0 !== 0) $display("FAIL basic_frame_err got %0d exp 0", fe_cnt - fe0); else passes++;
        checks++; if (dx !== 9'h005) $display("FAIL basic_dx got %h exp 005", dx); else passes++;
        // byte0[5]=0 so the Y sign is positive: {0,FB}
        checks++; if (dy !== 9'h0FB) $display("FAIL basic_dy got %h exp 0fb", dy); else passes++;
        checks++; if ({m1, m2, m3} !== 3'b100) $display("FAIL basic_buttons got %b exp 100", {m1, m2, m3}); else passes++;
    endtask

    task automatic test_negative();
        mark();
        send_pkt(8'h38, 8'h00, 8'h80);
        checks++; if (nd_cnt - nd0 !== 1) $display("FAIL neg_new_data got %0d exp 1", nd_cnt - nd0); else passes++;
        checks++; if (dx !== 9'h100) $display("FAIL neg_dx got %h exp 100", dx); else passes++;
        checks++; if (dy !== 9'h180) $display("FAIL neg_dy got %h exp 180", dy); else passes++;
        checks++; if ({m1, m2, m3} !== 3'b000) $display("FAIL neg_buttons got %b exp 000", {m1, m2, m3}); else passes++;
    endtask

    task automatic test_resync();
        mark();
        send_byte(8'h02, 1'b0);
        send_pkt(8'h0A, 8'h01, 8'h01);
        checks++; if (nd_cnt - nd0 !== 1) $display("FAIL resync_new_data got %0d exp 1", nd_cnt - nd0); else passes++;
        checks++; if ({m1, m2, m3} !== 3'b010) $display("FAIL resync_buttons got %b exp 010", {m1, m2, m3}); else passes++;
        checks++; if (dx !== 9'h001) $display("FAIL resync_dx got %h exp 001", dx); else passes++;
        checks++; if (dy !== 9'h001) $display("FAIL resync_dy got %h exp 001", dy); else passes++;
    endtask

    task automatic test_parity();
        mark();
        send_byte(8'h09, 1'b0);
        send_byte(8'h05, 1'b1);
        checks++; if (fe_cnt - fe0 !== 1) $display("FAIL par_frame_err got %0d exp 1", fe_cnt - fe0); else passes++;
        checks++; if (nd_cnt - nd0 !== 0) $display("FAIL par_no_new_data got %0d exp 0", nd_cnt - nd0); else passes++;
        mark();
        send_pkt(8'h18, 8'h7F, 8'h01);
        checks++; if (nd_cnt - nd0 !== 1) $display("FAIL par_recover_new_data got %0d exp 1", nd_cnt - nd0); else passes++;
        checks++; if (dx !== 9'h17F) $display("FAIL par_recover_dx got %h exp 17f", dx); else passes++;
        checks++; if (dy !== 9'h001) $display("FAIL par_recover_dy got %h exp 001", dy); else passes++;
    endtask

    task automatic test_timeout();
        mark();
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        PS2_DAT = 1'b1;
        repeat (TO + 10) @(negedge Clk);
        checks++; if (fe_cnt - fe0 !== 1) $display("FAIL to_frame_err got %0d exp 1", fe_cnt - fe0); else passes++;
        checks++; if (nd_cnt - nd0 !== 0) $display("FAIL to_no_new_data got %0d exp 0", nd_cnt - nd0); else passes++;
        mark();
        send_pkt(8'h09, 8'h02, 8'h03);
        checks++; if (nd_cnt - nd0 !== 1) $display("FAIL to_recover_new_data got %0d exp 1", nd_cnt - nd0); else passes++;
        checks++; if (fe_cnt - fe0 !== 0) $display("FAIL to_recover_frame_err got %0d exp 0", fe_cnt - fe0); else passes++;
        checks++; if (dx !== 9'h002) $display("FAIL to_recover_dx got %h exp 002", dx); else passes++;
        checks++; if (dy !== 9'h003) $display("FAIL to_recover_dy got %h exp 003", dy); else passes++;
    endtask

    task automatic test_overflow();
        logic [8:0] exp_dx_neg;
        logic [8:0] exp_dx_pos;
        logic [8:0] exp_dy_pos;
`ifdef MOUSE_OVF_SAT_EN
        exp_dx_neg = 9'h100;
        exp_dx_pos = 9'h0FF;
        exp_dy_pos = 9'h0FF;
`else
        exp_dx_neg = 9'h110;
        exp_dx_pos = 9'h010;
        exp_dy_pos = 9'h07F;
`endif
        send_pkt(8'h58, 8'h10, 8'h00);
        checks++; if (dx !== exp_dx_neg) $display("FAIL ovf58_dx got %h exp %h", dx, exp_dx_neg); else passes++;
        checks++; if (dy !== 9'h000) $display("FAIL ovf58_dy got %h exp 000", dy); else passes++;
        send_pkt(8'h48, 8'h10, 8'h00);
        checks++; if (dx !== exp_dx_pos) $display("FAIL ovf48_dx got %h exp %h", dx, exp_dx_pos); else passes++;
        checks++; if (dy !== 9'h000) $display("FAIL ovf48_dy got %h exp 000", dy); else passes++;
        send_pkt(8'h88, 8'h00, 8'h7F);
        checks++; if (dy !== exp_dy_pos) $display("FAIL ovf88_dy got %h exp %h", dy, exp_dy_pos); else passes++;
        checks++; if (dx !== 9'h000) $display("FAIL ovf88_dx got %h exp 000", dx); else passes++;
    endtask

    task automatic test_reset_mid();
        mark();
        send_byte(8'h09, 1'b0);
        @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        checks++; if (dx !== 9'h000) $display("FAIL midrst_dx got %h exp 000", dx); else passes++;
        checks++; if (dy !== 9'h000) $display("FAIL midrst_dy got %h exp 000", dy); else passes++;
        checks++; if ({m1, m2, m3, new_data, frame_err} !== 5'b00000) $display("FAIL midrst_flags got %b exp 00000", {m1, m2, m3, new_data, frame_err}); else passes++;
        Reset = 1'b0;
        repeat (4) @(negedge Clk);
        send_byte(8'h05, 1'b0);
        send_byte(8'h03, 1'b0);
        checks++; if (nd_cnt - nd0 !== 0) $display("FAIL midrst_stray_new_data got %0d exp 0", nd_cnt - nd0); else passes++;
        send_pkt(8'h0C, 8'h07, 8'h03);
        checks++; if (nd_cnt - nd0 !== 1) $display("FAIL midrst_new_data got %0d exp 1", nd_cnt - nd0); else passes++;
        checks++; if (dx !== 9'h007) $display("FAIL midrst_next_dx got %h exp 007", dx); else passes++;
        checks++; if ({m1, m2, m3} !== 3'b001) $display("FAIL midrst_next_buttons got %b exp 001", {m1, m2, m3}); else passes++;
    endtask

    task automatic test_back_to_back();
        mark();
        send_pkt(8'h09, 8'h01, 8'h02);
        send_pkt(8'h0B, 8'h03, 8'h04);
        checks++; if (nd_cnt - nd0 !== 2) $display("FAIL b2b_new_data got %0d exp 2", nd_cnt - nd0); else passes++;
        checks++; if (dx !== 9'h003) $display("FAIL b2b_dx got %h exp 003", dx); else passes++;
        checks++; if (dy !== 9'h004) $display("FAIL b2b_dy got %h exp 004", dy); else passes++;
        checks++; if ({m1, m2, m3} !== 3'b110) $display("FAIL b2b_buttons got %b exp 110", {m1, m2, m3}); else passes++;
        checks++; if (both_cnt !== 0) $display("FAIL exclusive_pulses got %0d exp 0", both_cnt); else passes++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_negative();
        test_resync();
        test_parity();
        test_timeout();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
